global_branch_pred: RTL and testbench
=====================================

// Module: global_branch_pred
// PURPOSE
//  Global-history (gshare) direction predictor inside the 5-stage MIPS pipeline of mips_global_pred.
//  - Lookup in Decode, once the instruction is known to be a branch.
//  - Carries its own D->E checkpoint and resolves in Execute.
//  - Drives pred_takenD to the D-stage PC mux and mispredictE to the hazard unit for recovery.
// PARAMETERS
//  INDEX_W  8  PHT index width; PHT holds 2**INDEX_W 2-bit counters
//  GHR_W    8  global history length; GHR_W <= INDEX_W, zero-extended to INDEX_W for hashing
// PORTS
//  clk            in   1        rising-edge clock
//  rst            in   1        synchronous, active-high reset
//  stallD         in   1        D stage held this cycle
//  flushD         in   1        D stage squashed this cycle
//  flushE         in   1        E stage receives a bubble at this edge
//  pcD            in   32       PC of the D-stage instruction
//  branchD        in   1        D-stage instruction is a conditional branch
//  actual_takenE  in   1        resolved direction of the E-stage instruction
//  pred_takenD    out  1        predicted taken for the D-stage branch (combinational)
//  mispredictE    out  1        E-stage branch direction was mispredicted (combinational)
//  ghr            out  GHR_W    speculative history (debug/testbench)
// BEHAVIOUR
//  Reset
//   - Every PHT entry = WNT (2'b01); ghr = 0.
//   - E checkpoint: validE=0, predE=0, idxE=0, ckptE=0.
//   - Hence pred_takenD=0 and mispredictE=0 out of reset.
//  Lookup (D, combinational)
//   - idxD = pcD[INDEX_W+1:2] ^ {0, ghr}.
//   - pred_takenD = branchD & ~flushD & pht[idxD][1].
//   - No bypass: a same-edge PHT write to idxD is not visible until the next cycle.
//  Speculative history (edge)
//   - If branchD & ~stallD & ~flushD: ghr <= {ghr[GHR_W-2:0], pred_takenD}.
//  D->E checkpoint (edge)
//   - flushE: validE <= 0.
//   - stallD & ~flushE: validE <= 0 (bubble; mirrors the pipeline's stallD => bubble in E).
//   - Otherwise: validE <= branchD & ~flushD; predE <= pred_takenD; idxE <= idxD;
//     ckptE <= ghr (the value before this edge's shift).
//  Resolve (E)
//   - mispredictE = validE & (predE != actual_takenE).
//   - If validE, at the edge pht[idxE] moves one step toward actual_takenE, saturating at 00 and 11.
//  Recovery
//   - If mispredictE: ghr <= {ckptE[GHR_W-2:0], actual_takenE}.
//   - This overrides any same-edge D-stage speculative shift; that D instruction is wrong-path.
//   - The same-edge PHT update still happens.
//   - The hazard unit flushes D/E on mispredictE. That flush is outside this block.
//  Boundaries
//   - GHR shifts out its MSB (no wrap state).
//   - Counter stays 11 on taken and 00 on not-taken.
//   - Back-to-back branches: the second lookup sees the first's speculative bit.
//   - rst mid-stream: all state returns to reset values at that edge; rst beats every other input.
// STRUCTURE
//  - Shared package: counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11, and a
//    sat_next(ctr, taken) function.
//  - Sub-module pht_2bit: counter array with one combinational read port (idxD), one
//    synchronous write port (idxE, taken, we), and sync reset to WNT.
//  - Top level holds ghr, the E checkpoint, and the recovery mux.
// TESTING
//  1. Reset, then branchD=1, pcD=0x0000_0010: pred_takenD=0, ghr=0x00; after 1 edge ghr=0x00.
//  2. Same branch at the same ghr, resolved taken 2 times: pht[idx] 01->10->11;
//     the next lookup at that idx gives pred_takenD=1.
//  3. predE=0, actual_takenE=1, ckptE=0x05:
//     - mispredictE=1 in that cycle; next edge ghr=0x0B even though branchD=1 that cycle.
//  4. Counter at 11, resolved taken: stays 11. Counter at 00, resolved not-taken: stays 00.
//     mispredictE=0 both times.
//  5. branchD=1 with stallD=1 for 2 cycles:
//     - ghr unchanged and validE=0 in both; after release, exactly one shift and one resolve.
//  6. rst asserted while validE=1 and mispredictE=1:
//     - next edge ghr=0, validE=0, all PHT entries=01; the misprediction is not recovered.

Source files
------------

// File: rtl/global_branch_pred_pkg.sv
`default_nettype none
// ============================================================================
// Module   : global_branch_pred_pkg
// Purpose  : Shared types and helpers for the gshare direction predictor.
//            Provides the 2-bit saturating counter encodings and the
//            counter-update function used by the pattern history table.
// Revision : 1.0 - initial release
// ============================================================================
package global_branch_pred_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;   // strongly not-taken
    localparam ctr_t WNT = 2'b01;   // weakly not-taken (reset value)
    localparam ctr_t WT  = 2'b10;   // weakly taken
    localparam ctr_t ST  = 2'b11;   // strongly taken

    // One saturating step of a counter toward the resolved direction.
    function automatic ctr_t sat_next(input ctr_t ctr, input logic taken);
        ctr_t r;
        if (taken) begin
            r = (ctr == ST) ? ST : ctr + 2'd1;
        end else begin
            r = (ctr == SNT) ? SNT : ctr - 2'd1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/global_branch_pred_if.sv
`default_nettype none
// ============================================================================
// Module   : global_branch_pred_if
// Purpose  : Pipeline <-> predictor signal bundle.
//   master : pipeline side, drives stall/flush, D-stage PC/branch flag and
//            the resolved E-stage direction; receives prediction outputs.
//   slave  : predictor side.
//   Signals: stallD, flushD, flushE, pcD[31:0], branchD, actual_takenE,
//            pred_takenD, mispredictE, ghr[GHR_W-1:0]
// Revision : 1.0 - initial release
// ============================================================================
interface global_branch_pred_if #(
    parameter int GHR_W = 8
);
    logic             stallD;
    logic             flushD;
    logic             flushE;
    logic [31:0]      pcD;
    logic             branchD;
    logic             actual_takenE;
    logic             pred_takenD;
    logic             mispredictE;
    logic [GHR_W-1:0] ghr;

    modport master (
        output stallD, flushD, flushE, pcD, branchD, actual_takenE,
        input  pred_takenD, mispredictE, ghr
    );

    modport slave (
        input  stallD, flushD, flushE, pcD, branchD, actual_takenE,
        output pred_takenD, mispredictE, ghr
    );
endinterface
`default_nettype wire

// File: rtl/global_branch_pred_pht_2bit.sv
`default_nettype none
// ============================================================================
// Module   : pht_2bit
// Purpose  : Pattern history table of 2**INDEX_W two-bit saturating counters.
//   clk, rst  : clock, synchronous active-high reset (all entries -> WNT)
//   rd_idx    : combinational read index; rd_ctr is the counter there
//   wr_en     : update enable; wr_idx entry steps toward wr_taken
//   A write is not forwarded to a same-cycle read of the same entry.
// Revision : 1.0 - initial release
// ============================================================================
module pht_2bit
    import global_branch_pred_pkg::*;
#(
    parameter int INDEX_W = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [INDEX_W-1:0] rd_idx,
    output ctr_t                    rd_ctr,
    input  wire logic [INDEX_W-1:0] wr_idx,
    input  wire logic               wr_taken,
    input  wire logic               wr_en
);
    localparam int DEPTH = 1 << INDEX_W;

    ctr_t pht_q [DEPTH];
    ctr_t pht_d [DEPTH];

    assign rd_ctr = pht_q[rd_idx];

    always_comb begin
        pht_d = pht_q;
        if (wr_en) begin
            pht_d[wr_idx] = sat_next(pht_q[wr_idx], wr_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht_q[i] <= WNT;
            end
        end else begin
            pht_q <= pht_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/global_branch_pred.sv
`default_nettype none
// ============================================================================
// Module   : global_branch_pred
// Purpose  : gshare direction predictor. Looks up in Decode, carries its own
//            D->E checkpoint and resolves/recovers in Execute.
//   clk, rst : clock, synchronous active-high reset
//   bp       : slave side of global_branch_pred_if
//              (stallD, flushD, flushE, pcD, branchD, actual_takenE in;
//               pred_takenD, mispredictE, ghr out)
// Revision : 1.0 - initial release
// ============================================================================
module global_branch_pred
    import global_branch_pred_pkg::*;
#(
    parameter int INDEX_W = 8,
    parameter int GHR_W   = 8
) (
    input wire logic       clk,
    input wire logic       rst,
    global_branch_pred_if.slave bp
);
    logic [GHR_W-1:0]   ghr_q,     ghr_d;
    logic               valid_e_q, valid_e_d;
    logic               pred_e_q,  pred_e_d;
    logic [INDEX_W-1:0] idx_e_q,   idx_e_d;
    logic [GHR_W-1:0]   ckpt_e_q,  ckpt_e_d;

    logic [INDEX_W-1:0] idx_lookup;
    ctr_t               rd_ctr;
    logic               pred_taken;
    logic               mispredict;
    logic               unused_pc;

    // Word-aligned PC bits hashed with the zero-extended history.
    assign idx_lookup = bp.pcD[INDEX_W+1:2] ^ INDEX_W'(ghr_q);
    assign unused_pc  = ^{bp.pcD[31:INDEX_W+2], bp.pcD[1:0]};

    pht_2bit #(
        .INDEX_W (INDEX_W)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx_lookup),
        .rd_ctr   (rd_ctr),
        .wr_idx   (idx_e_q),
        .wr_taken (bp.actual_takenE),
        .wr_en    (valid_e_q)
    );

    assign pred_taken = bp.branchD & ~bp.flushD & rd_ctr[1];
    assign mispredict = valid_e_q & (pred_e_q != bp.actual_takenE);

    assign bp.pred_takenD = pred_taken;
    assign bp.mispredictE = mispredict;
    assign bp.ghr         = ghr_q;

    always_comb begin
        ghr_d     = ghr_q;
        valid_e_d = valid_e_q;
        pred_e_d  = pred_e_q;
        idx_e_d   = idx_e_q;
        ckpt_e_d  = ckpt_e_q;

        // Recovery wins: the D-stage instruction this cycle is wrong-path.
        if (mispredict) begin
            ghr_d = {ckpt_e_q[GHR_W-2:0], bp.actual_takenE};
        end else if (bp.branchD & ~bp.stallD & ~bp.flushD) begin
            ghr_d = {ghr_q[GHR_W-2:0], pred_taken};
        end

        // A stalled D stage hands a bubble to E, same as a flush.
        if (bp.flushE | bp.stallD) begin
            valid_e_d = 1'b0;
        end else begin
            valid_e_d = bp.branchD & ~bp.flushD;
            pred_e_d  = pred_taken;
            idx_e_d   = idx_lookup;
            ckpt_e_d  = ghr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q     <= '0;
            valid_e_q <= 1'b0;
            pred_e_q  <= 1'b0;
            idx_e_q   <= '0;
            ckpt_e_q  <= '0;
        end else begin
            ghr_q     <= ghr_d;
            valid_e_q <= valid_e_d;
            pred_e_q  <= pred_e_d;
            idx_e_q   <= idx_e_d;
            ckpt_e_q  <= ckpt_e_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_global_branch_pred.sv
`default_nettype none
// ============================================================================
// Module   : tb_global_branch_pred
// Purpose  : Self-checking bench for global_branch_pred. A behavioural model
//            of counters/history/checkpoint is compared against the DUT every
//            cycle; directed scenarios add hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_global_branch_pred;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    global_branch_pred_if #(.GHR_W(8)) bp ();

    global_branch_pred #(
        .INDEX_W (8),
        .GHR_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    // Behavioural model state
    int m_pht [256];
    int m_ghr;
    bit m_valid;
    bit m_pred;
    int m_idx_e;
    int m_ckpt;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    function automatic int exp_idx();
        return ((int'(bp.pcD) >> 2) & 255) ^ m_ghr;
    endfunction

    function automatic bit exp_pred();
        return bp.branchD && !bp.flushD && (m_pht[exp_idx()] >= 2);
    endfunction

    function automatic bit exp_mis();
        return m_valid && (m_pred != bp.actual_takenE);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pred_takenD", int'(bp.pred_takenD), int'(exp_pred()));
            check("model_mispredictE", int'(bp.mispredictE), int'(exp_mis()));
            check("model_ghr",         int'(bp.ghr),         m_ghr);
        end
    end

    // Apply one cycle of inputs; returns just after the falling edge so the
    // caller can make literal checks on the combinational outputs.
    task automatic drive(input bit r, input bit s, input bit fd, input bit fe,
                         input bit br, input bit act, input int idx);
        rst              = r;
        bp.stallD        = s;
        bp.flushD        = fd;
        bp.flushE        = fe;
        bp.branchD       = br;
        bp.actual_takenE = act;
        bp.pcD           = 32'(((idx ^ m_ghr) & 255) << 2);
        @(negedge clk);
        #1;
    endtask

    // Advance the model across the rising edge using pre-edge state.
    task automatic commit();
        bit p, mis, act;
        int ix, g;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 256; i++) m_pht[i] = 1;
            m_ghr = 0; m_valid = 0; m_pred = 0; m_idx_e = 0; m_ckpt = 0;
        end else begin
            p   = exp_pred();
            mis = exp_mis();
            ix  = exp_idx();
            g   = m_ghr;
            act = bp.actual_takenE;
            if (m_valid)
                m_pht[m_idx_e] = act ? ((m_pht[m_idx_e] == 3) ? 3 : m_pht[m_idx_e] + 1)
                                     : ((m_pht[m_idx_e] == 0) ? 0 : m_pht[m_idx_e] - 1);
            if (mis)
                m_ghr = ((m_ckpt << 1) | int'(act)) & 255;
            else if (bp.branchD && !bp.stallD && !bp.flushD)
                m_ghr = ((g << 1) | int'(p)) & 255;
            if (bp.flushE || bp.stallD) begin
                m_valid = 0;
            end else begin
                m_valid = bp.branchD && !bp.flushD;
                m_pred  = p;
                m_idx_e = ix;
                m_ckpt  = g;
            end
        end
        #1;
    endtask

    initial begin
        m_ghr = 0;
        drive(1, 0, 0, 0, 0, 0, 0); commit();
        chk_en = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        check("reset_pred", int'(bp.pred_takenD), 0);
        check("reset_mis",  int'(bp.mispredictE), 0);
        check("reset_ghr",  int'(bp.ghr), 0);
        commit();

        // T1: first lookup at pc 0x10
        drive(0, 0, 0, 0, 1, 0, 4);
        check("t1_pcD", int'(bp.pcD), 32'h10);
        check("t1_pred", int'(bp.pred_takenD), 0);
        check("t1_ghr", int'(bp.ghr), 0);
        commit();
        check("t1_ghr_after", int'(bp.ghr), 0);

        // T2: train idx 4 toward taken
        drive(0, 0, 0, 0, 0, 1, 0); check("t2_mis_first", int'(bp.mispredictE), 1); commit();
        drive(0, 0, 0, 0, 1, 0, 4); check("t2_pred_wt", int'(bp.pred_takenD), 1); commit();
        drive(0, 0, 0, 0, 0, 1, 0); check("t2_mis_none", int'(bp.mispredictE), 0); commit();
        drive(0, 0, 0, 0, 1, 0, 4);
        check("t2_pred_st", int'(bp.pred_takenD), 1);
        check("t2_ghr", int'(bp.ghr), 3);
        commit();

        // T4 high side: 11 + taken stays 11
        drive(0, 0, 0, 0, 0, 1, 0); check("t4_hi_mis", int'(bp.mispredictE), 0); commit();
        drive(0, 0, 0, 0, 1, 0, 4); commit();
        drive(0, 0, 0, 0, 0, 0, 0); check("t4_hi_nt_mis", int'(bp.mispredictE), 1); commit();
        check("t4_hi_recover_ghr", int'(bp.ghr), 8'h0E);
        drive(0, 0, 0, 0, 1, 0, 4); check("t4_hi_held", int'(bp.pred_takenD), 1); commit();
        drive(0, 0, 0, 0, 0, 1, 0); commit();

        // T4 low side: 00 + not-taken stays 00
        drive(0, 0, 0, 0, 1, 0, 8'h20); commit();
        drive(0, 0, 0, 0, 0, 0, 0); commit();
        drive(0, 0, 0, 0, 1, 0, 8'h20); commit();
        drive(0, 0, 0, 0, 0, 0, 0); check("t4_lo_mis", int'(bp.mispredictE), 0); commit();
        drive(0, 0, 0, 0, 1, 0, 8'h20); commit();
        drive(0, 0, 0, 0, 0, 1, 0); commit();
        drive(0, 0, 0, 0, 1, 0, 8'h20); check("t4_lo_held", int'(bp.pred_takenD), 0); commit();
        drive(0, 0, 0, 0, 0, 0, 0); commit();

        // flushD suppresses prediction and shift; flushE drops the checkpoint
        drive(0, 0, 1, 0, 1, 0, 4); check("fd_pred", int'(bp.pred_takenD), 0); commit();
        check("fd_ghr", int'(bp.ghr), 8'hD2);
        drive(0, 0, 0, 0, 0, 1, 0); check("fd_no_resolve", int'(bp.mispredictE), 0); commit();
        drive(0, 0, 0, 1, 1, 0, 4); check("fe_pred", int'(bp.pred_takenD), 1); commit();
        check("fe_ghr", int'(bp.ghr), 8'hA5);
        drive(0, 0, 0, 0, 0, 0, 0); check("fe_no_resolve", int'(bp.mispredictE), 0); commit();

        // T3: build ghr = 0x05 then recover over a concurrent D-stage branch
        drive(1, 0, 0, 0, 0, 0, 0); commit();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, 0, 8'h40 + k); commit();
            drive(0, 0, 0, 0, 0, (k != 1), 0); commit();
        end
        check("t3_ghr5", int'(bp.ghr), 5);
        drive(0, 0, 0, 0, 1, 0, 8'h50); check("t3_pred", int'(bp.pred_takenD), 0); commit();
        drive(0, 0, 0, 0, 1, 1, 8'h60);
        check("t3_mis", int'(bp.mispredictE), 1);
        check("t3_ghr_before", int'(bp.ghr), 8'h0A);
        commit();
        check("t3_ghr_recovered", int'(bp.ghr), 8'h0B);
        drive(0, 0, 0, 0, 0, 0, 0); commit();

        // T5: stalled branch, then one shift and one resolve
        drive(0, 1, 0, 0, 1, 0, 8'h70); commit();
        check("t5_ghr_stall1", int'(bp.ghr), 8'h0B);
        drive(0, 1, 0, 0, 1, 1, 8'h70); check("t5_no_valid", int'(bp.mispredictE), 0); commit();
        check("t5_ghr_stall2", int'(bp.ghr), 8'h0B);
        drive(0, 0, 0, 0, 1, 1, 8'h70); check("t5_release_mis", int'(bp.mispredictE), 0); commit();
        check("t5_ghr_shift", int'(bp.ghr), 8'h16);
        drive(0, 0, 0, 0, 0, 1, 0); check("t5_resolve", int'(bp.mispredictE), 1); commit();
        check("t5_ghr_recover", int'(bp.ghr), 8'h17);
        drive(0, 0, 0, 0, 0, 1, 0); check("t5_single_resolve", int'(bp.mispredictE), 0); commit();

        // T6: reset beats a pending misprediction
        drive(0, 0, 0, 0, 1, 0, 4); commit();
        drive(1, 0, 0, 0, 0, 1, 0); check("t6_mis_at_rst", int'(bp.mispredictE), 1); commit();
        drive(0, 0, 0, 0, 1, 1, 8'h40);
        check("t6_mis_after", int'(bp.mispredictE), 0);
        check("t6_ghr", int'(bp.ghr), 0);
        check("t6_pht_reset", int'(bp.pred_takenD), 0);
        commit();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
